// File: rtl/variance_norm_calc_multi_pkg.sv
// Shared definitions for the variance normaliser.
//   vnc_state_e : controller state encoding
//   CORNER_ADD  : per-corner sign of the integral-image combination (A,B,C,D) = (+,-,-,+)
//   one_q()     : fixed-point 1.0 for a given number of fractional bits
package pkg_variance_norm;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDrain,
        StMulMean,
        StMulSq,
        StMulMean2,
        StSub,
        StCheck,
        StSqrt,
        StDone
    } vnc_state_e;

    // Bit k set: corner k is added, clear: subtracted.
    localparam logic [3:0] CORNER_ADD = 4'b1001;

    function automatic logic [63:0] one_q(input int unsigned frac);
        return 64'd1 << frac;
    endfunction

endpackage

// File: rtl/variance_norm_calc_multi_sqrt.sv
// Bit-serial non-restoring integer square root.
//   clk, resetn : clock, asynchronous active-low reset
//   start       : load radicand and perform the first iteration in the same cycle
//   radicand    : RAD_W-bit unsigned input (RAD_W must be even)
//   busy        : iterations still in progress
//   done        : one-cycle pulse, RAD_W/2 cycles after start; root is then final
//   root        : floor(sqrt(radicand))
module var_sqrt_serial #(
    parameter int unsigned RAD_W = 48
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [RAD_W-1:0]   radicand,
    output logic               busy,
    output logic               done,
    output logic [RAD_W/2-1:0] root
);

    localparam int unsigned HALF = RAD_W / 2;
    // Partial remainder magnitude stays below 2*root+2, so HALF+3 bits signed is ample.
    localparam int unsigned RW   = HALF + 3;
    localparam int unsigned CW   = $clog2(HALF + 1);

    logic [RW-1:0]    rem_q, r_in, r_sh, r_nx;
    logic [HALF-1:0]  root_q, q_in, q_nx;
    logic [RAD_W-1:0] rad_q;
    logic [1:0]       pair;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;
    logic             unused_rem;

    always_comb begin
        r_in = start ? '0 : rem_q;
        q_in = start ? '0 : root_q;
        pair = start ? radicand[RAD_W-1 -: 2] : rad_q[RAD_W-1 -: 2];
        r_sh = {r_in[RW-3:0], pair};
        // Negative remainder is corrected by adding instead of restoring.
        if (!r_in[RW-1]) begin
            r_nx = r_sh - RW'({q_in, 2'b01});
        end else begin
            r_nx = r_sh + RW'({q_in, 2'b11});
        end
        q_nx = HALF'({q_in, ~r_nx[RW-1]});
    end

    assign unused_rem = r_in[RW-2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            root_q <= '0;
            rad_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= r_nx;
                root_q <= q_nx;
                rad_q  <= {radicand[RAD_W-3:0], 2'b00};
                cnt_q  <= CW'(HALF - 1);
                busy_q <= (HALF > 1);
                if (HALF == 1) begin
                    done_q <= 1'b1;
                end
            end else if (busy_q) begin
                rem_q  <= r_nx;
                root_q <= q_nx;
                rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign root = root_q;

endmodule

// File: rtl/variance_norm_calc_multi.sv
// Per-window variance normaliser: fetches four integral-image corners (sum and squared sum)
// from a selectable bank, computes mean/variance in Q(FRAC) and returns sqrt(variance),
// or 1.0 when the variance is non-positive or below the programmable threshold.
//   clk, resetn                    : clock, asynchronous active-low reset
//   in_valid/in_ready              : request handshake; in_buf, inv_area, thresh latched on accept
//   rd_addr, rd_buf                : corner index 0..3 and bank select to the cache
//   rd_sum, rd_sqsum               : per-bank corner data, READ_LAT cycles after rd_addr
//   out_valid/out_ready            : result handshake; norm_factor, clamped held while valid
// Optional build macro VNC_STATS_EN adds stat_clr, stat_total, stat_clamped (saturating).
module variance_norm_calc_multi
    import pkg_variance_norm::*;
#(
    parameter int unsigned FIXED_W  = 32,
    parameter int unsigned FRAC     = 16,
    parameter int unsigned SUM_W    = 32,
    parameter int unsigned SQSUM_W  = 32,
    parameter int unsigned NUM_BUF  = 2,
    parameter int unsigned READ_LAT = 1,
    localparam int unsigned BUF_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BUF_W-1:0]           in_buf,
    input  logic [FIXED_W-1:0]         inv_area,
    input  logic [FIXED_W-1:0]         thresh,
    output logic [1:0]                 rd_addr,
    output logic [BUF_W-1:0]           rd_buf,
    input  logic [NUM_BUF*SUM_W-1:0]   rd_sum,
    input  logic [NUM_BUF*SQSUM_W-1:0] rd_sqsum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [FIXED_W-1:0]         norm_factor,
    output logic                       clamped
`ifdef VNC_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [15:0]                stat_total,
    output logic [15:0]                stat_clamped
`endif
);

    localparam int unsigned MW0   = (SUM_W > SQSUM_W) ? SUM_W : SQSUM_W;
    localparam int unsigned MW    = (MW0 > FIXED_W) ? MW0 : FIXED_W;
    localparam int unsigned PW    = 2 * MW;
    localparam int unsigned RAD_W = FIXED_W + FRAC;
    localparam int unsigned HALF  = RAD_W / 2;

    vnc_state_e          state_q;
    logic [BUF_W-1:0]    buf_q;
    logic [FIXED_W-1:0]  inv_q, thresh_q, mean_q, msq_q, norm_q;
    logic [SUM_W-1:0]    s_q, sum_sel;
    logic [SQSUM_W-1:0]  q_q, sq_sel;
    logic [1:0]          rd_addr_q;
    logic [PW-1:0]       prod_q, product;
    logic [MW-1:0]       mul_a, mul_b;
    logic signed [FIXED_W:0] var_q;
    logic [FIXED_W-1:0]  m2;
    logic                clamped_q, out_valid_q, in_ready_q;
    logic                clamp_cond, sqrt_start, sqrt_done, sqrt_busy;
    logic [RAD_W-1:0]    radicand;
    logic [HALF-1:0]     sqrt_root;
    logic                unused_bits;
    int                  bank_idx;

    // Read-return tracking: stage READ_LAT-1 marks the cycle whose data is on rd_sum.
    logic [READ_LAT-1:0] vld_q;
    logic [1:0]          addr_pipe_q [READ_LAT];
    logic                samp_vld;
    logic [1:0]          samp_addr;

    always_comb begin
        bank_idx  = (int'(buf_q) < int'(NUM_BUF)) ? int'(buf_q) : 0;
        sum_sel   = rd_sum[bank_idx*SUM_W +: SUM_W];
        sq_sel    = rd_sqsum[bank_idx*SQSUM_W +: SQSUM_W];
        samp_vld  = vld_q[READ_LAT-1];
        samp_addr = addr_pipe_q[READ_LAT-1];
    end

    // Single shared multiplier; operands chosen by the current multiply state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            StMulMean: begin
                mul_a = MW'(s_q);
                mul_b = MW'(inv_q);
            end
            StMulSq: begin
                mul_a = MW'(q_q);
                mul_b = MW'(inv_q);
            end
            StMulMean2: begin
                mul_a = MW'(mean_q);
                mul_b = MW'(mean_q);
            end
            default: ;
        endcase
        product = PW'(mul_a) * PW'(mul_b);
    end

    always_comb begin
        m2         = FIXED_W'(prod_q >> FRAC);
        clamp_cond = var_q[FIXED_W] || (var_q == '0) || (var_q < $signed({1'b0, thresh_q}));
        sqrt_start = (state_q == StCheck) && !clamp_cond;
        radicand   = RAD_W'(var_q[FIXED_W-1:0]) << FRAC;
    end

    assign unused_bits = ^{prod_q, sqrt_root, sqrt_busy};

    var_sqrt_serial #(
        .RAD_W (RAD_W)
    ) u_sqrt (
        .clk      (clk),
        .resetn   (resetn),
        .start    (sqrt_start),
        .radicand (radicand),
        .busy     (sqrt_busy),
        .done     (sqrt_done),
        .root     (sqrt_root)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                addr_pipe_q[i] <= '0;
            end
        end else begin
            vld_q[0]       <= (state_q == StFetch);
            addr_pipe_q[0] <= rd_addr_q;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                vld_q[i]       <= vld_q[i-1];
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            buf_q       <= '0;
            inv_q       <= '0;
            thresh_q    <= '0;
            s_q         <= '0;
            q_q         <= '0;
            rd_addr_q   <= '0;
            prod_q      <= '0;
            mean_q      <= '0;
            msq_q       <= '0;
            var_q       <= '0;
            norm_q      <= '0;
            clamped_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            if (samp_vld) begin
                if (CORNER_ADD[samp_addr]) begin
                    s_q <= s_q + sum_sel;
                    q_q <= q_q + sq_sel;
                end else begin
                    s_q <= s_q - sum_sel;
                    q_q <= q_q - sq_sel;
                end
            end
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        buf_q      <= in_buf;
                        inv_q      <= inv_area;
                        thresh_q   <= thresh;
                        s_q        <= '0;
                        q_q        <= '0;
                        rd_addr_q  <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StFetch;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                StFetch: begin
                    if (rd_addr_q == 2'd3) begin
                        state_q <= StDrain;
                    end else begin
                        rd_addr_q <= rd_addr_q + 2'd1;
                    end
                end
                StDrain: begin
                    if (samp_vld && (samp_addr == 2'd3)) begin
                        state_q <= StMulMean;
                    end
                end
                StMulMean: begin
                    prod_q  <= product;
                    state_q <= StMulSq;
                end
                StMulSq: begin
                    mean_q  <= prod_q[FIXED_W-1:0];
                    prod_q  <= product;
                    state_q <= StMulMean2;
                end
                StMulMean2: begin
                    msq_q   <= prod_q[FIXED_W-1:0];
                    prod_q  <= product;
                    state_q <= StSub;
                end
                StSub: begin
                    var_q   <= $signed({1'b0, msq_q}) - $signed({1'b0, m2});
                    state_q <= StCheck;
                end
                StCheck: begin
                    if (clamp_cond) begin
                        norm_q      <= FIXED_W'(one_q(FRAC));
                        clamped_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        state_q <= StSqrt;
                    end
                end
                StSqrt: begin
                    if (sqrt_done) begin
                        norm_q      <= FIXED_W'(sqrt_root);
                        clamped_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign rd_addr     = rd_addr_q;
    assign rd_buf      = buf_q;
    assign out_valid   = out_valid_q;
    assign norm_factor = norm_q;
    assign clamped     = clamped_q;

`ifdef VNC_STATS_EN
    logic [15:0] stat_total_q, stat_clamped_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_total_q   <= '0;
            stat_clamped_q <= '0;
        end else if (stat_clr) begin
            stat_total_q   <= '0;
            stat_clamped_q <= '0;
        end else if (out_valid_q && out_ready) begin
            if (stat_total_q != 16'hffff) begin
                stat_total_q <= stat_total_q + 16'd1;
            end
            if (clamped_q && (stat_clamped_q != 16'hffff)) begin
                stat_clamped_q <= stat_clamped_q + 16'd1;
            end
        end
    end

    assign stat_total   = stat_total_q;
    assign stat_clamped = stat_clamped_q;
`endif

endmodule

// File: doc/variance_norm_calc_multi.md
Name: variance_norm_calc_multi

Overview:
- Parametrised successor of the per-window variance normaliser in the openCV face-detect pipeline.
- Reads four integral-image corners (sum and squared-sum) from one of NUM_BUF cache banks and computes mean and variance.
- Outputs sqrt(variance) in fixed point, or 1.0 when variance is non-positive or below threshold.
- Adds valid/ready handshakes on both sides, configurable read latency, a programmable threshold and a deterministic bit-serial square root.

Parameters:
- FIXED_W, 32, width of fixed-point datapath words (inv_area, result).
- FRAC, 16, fractional bits of all fixed-point values.
- SUM_W, 32, width of integral-image sum corners.
- SQSUM_W, 32, width of squared-sum corners.
- NUM_BUF, 2, number of cache banks selectable per request (>=1).
- READ_LAT, 1, cycles from rd_addr to valid rd_sum/rd_sqsum (1..4).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block idle and accepting.
- in_buf  in  max(1,$clog2(NUM_BUF))  bank to read, latched on accept.
- inv_area  in  FIXED_W  1/window_area, Q(FRAC), latched on accept.
- thresh  in  FIXED_W  variance cut-off, Q(FRAC), latched on accept.
- rd_addr  out  2  corner index 0..3 (A,B,C,D).
- rd_buf  out  max(1,$clog2(NUM_BUF))  latched bank select.
- rd_sum  in  NUM_BUF*SUM_W  per-bank sum data, bank b at [b*SUM_W +: SUM_W].
- rd_sqsum  in  NUM_BUF*SQSUM_W  per-bank squared-sum data.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accepts.
- norm_factor  out  FIXED_W  normalisation factor, Q(FRAC).
- clamped  out  1  result forced to 1.0.

Behaviour:
- Async reset clears: state Idle, in_ready=0 during reset then 1 in Idle, out_valid=0, norm_factor=0, clamped=0, rd_addr=0, all accumulators 0.
- Reset asserted mid-operation aborts immediately; no partial result is emitted.
- States: Idle, Fetch, Drain, MulMean, MulSq, MulMean2, Sub, Check, Sqrt, Done.
- Idle:
  - in_ready=1.
  - On in_valid&in_ready: latch in_buf, inv_area, thresh; zero accumulators; go Fetch.
- Fetch:
  - Issue rd_addr 0,1,2,3 on consecutive cycles.
  - Data for address k is sampled READ_LAT cycles later from bank rd_buf.
  - Accumulate S = A−B−C+D and Q = qA−qB−qC+qD in SUM_W and SQSUM_W, modulo 2^width.
  - After addr 3 is issued, go to Drain; Drain waits until the last sample is taken. Total fetch time is 4+READ_LAT cycles.
- MulMean: mean = (S*inv_area) truncated to FIXED_W, Q(FRAC).
- MulSq: msq = (Q*inv_area) truncated to FIXED_W.
- MulMean2: m2 = (mean*mean)>>FRAC, truncated. Uses one shared multiplier with a registered product, one product per state.
- Sub: var = msq − m2, computed signed at FIXED_W+1 bits.
- Check:
  - If var<=0 or var<thresh: norm_factor=1<<FRAC, clamped=1, go Done.
  - Otherwise start the sqrt sub-module with radicand var<<FRAC.
- Sqrt:
  - Wait for sqrt done, which takes exactly (FIXED_W+FRAC)/2 cycles.
  - norm_factor = root truncated to FIXED_W; clamped=0.
- Done:
  - out_valid=1, with norm_factor and clamped stable.
  - On out_ready, out_valid drops next cycle and the block returns to Idle.
  - out_ready may be high before out_valid; acceptance then takes effect on the first Done cycle.
- in_ready is 0 in every state except Idle; a new request is never accepted in the same cycle as output acceptance.
- Latency from accept to out_valid, unclamped, at defaults: 5+3+1+1+24 = 34 cycles.

Optional Feature:
- Macro: VNC_STATS_EN.
- When defined:
  - Adds outputs stat_total (16b) and stat_clamped (16b), both saturating.
  - Both increment on each output handshake; stat_clamped increments only when clamped=1.
  - Adds input stat_clr (1b), which zeroes both counters synchronously; stat_clr wins over a simultaneous increment.
  - Async reset clears both counters.
- When undefined: these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package pkg_variance_norm holds:
  - the state enum typedef;
  - the ONE_Q localparam function (1<<FRAC);
  - the corner sign constants {+,−,−,+}.
- Sub-module var_sqrt_serial(clk, resetn, start, radicand[FIXED_W+FRAC], busy, done, root[(FIXED_W+FRAC)/2]):
  - non-restoring, one result bit per cycle;
  - done pulses once per start.

Test Plan:
- Unclamped path: bank0 corners sum A=100,B=40,C=30,D=10 and sq 1000,300,250,50; inv_area=16384 (0.25); thresh=0 -> norm_factor=327680 (5.0), clamped=0, out_valid 34 cycles after accept.
- Bank select: same values on bank1, zeros on bank0, in_buf=1 -> 327680; in_buf=0 -> 65536, clamped=1.
- Threshold clamp: variance 25.0 with thresh=26<<16 -> 65536, clamped=1; with thresh=25<<16 -> 327680.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and norm_factor stable, in_ready=0; release -> Idle next cycle, and a back-to-back second request is accepted.
- Reset mid-Sqrt: assert resetn=0 -> out_valid=0 immediately; after release a fresh request returns the correct result.
- READ_LAT=3 build with the first vector -> result 327680, latency 36 cycles; with VNC_STATS_EN, after 3 results of which 1 is clamped -> stat_total=3, stat_clamped=1.
